// File: rtl/mem_scan_display.sv
// mem_scan_display
//   Scans a small register memory through its combinational read port,
//   showing each entry on a 7-segment display for DWELL cycles with a
//   one-cycle blank between entries. Sums the entries of every full pass
//   and reports that sum together with a one-cycle frame_done pulse.
//
// Ports
//   clk_2       in   system clock
//   reset       in   synchronous, active-high reset
//   scan_en     in   level, 1 = scanning active (dropping it returns to IDLE)
//   hold        in   level, 1 = freeze dwell counter and address in SHOW
//   rd_data     in   read data of the memory at rd_addr (combinational)
//   rd_addr     out  registered memory read address
//   seg         out  registered 7-segment pattern, gfedcba in [6:0], dp in [7]
//   led         out  status: [1:0] addr, [2] hold, [3] showing, [7:4] data
//   frame_done  out  one-cycle pulse after each completed pass
//   frame_sum   out  sum of the entries of the last completed pass
//
// State table
//   state | meaning
//   IDLE  | not scanning; display dark, address and sum-in-progress cleared
//   SHOW  | displaying the entry at rd_addr, counting dwell cycles
//   BLANK | one dark cycle between entries; advances the address
//
// All outputs are registered from the current state, so the display lags
// the state by one cycle: an entry becomes visible the cycle after SHOW is
// entered and the blank becomes visible the cycle after BLANK.

module mem_scan_display #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DWELL      = 4,
  parameter int NBITS_SEG  = 8
) (
  input  logic                             clk_2,
  input  logic                             reset,
  input  logic                             scan_en,
  input  logic                             hold,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [NBITS_SEG-1:0]             seg,
  output logic [7:0]                       led,
  output logic                             frame_done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] frame_sum
);

  localparam int SUM_WIDTH = DATA_WIDTH + ADDR_WIDTH;
  localparam int DW        = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW-1:0]         DWELL_LAST = DW'(DWELL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [SUM_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   disp_q, disp_d;
  logic [NBITS_SEG-1:0]    seg_q, seg_d;
  logic [7:0]              led_q, led_d;
  logic                    frame_done_q, frame_done_d;
  logic [SUM_WIDTH-1:0]    frame_sum_q, frame_sum_d;

  logic                    first_cycle;
  logic                    sample;
  logic [DATA_WIDTH-1:0]   show_val;
  logic [NBITS_SEG-1:0]    seg_pattern;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // The entry is captured on the one SHOW cycle where the dwell counter
  // leaves zero. Holding on that cycle delays the capture rather than
  // repeating it, so each visit latches the memory exactly once.
  assign first_cycle = (dwell_q == '0);
  assign sample      = (state_q == SHOW) && first_cycle && !hold;

  // With DWELL=1 the capture and the accumulation fall in the same cycle,
  // so the sum must take the live read data rather than the latch.
  assign show_val = first_cycle ? rd_data : disp_q;

  always_comb begin
    seg_pattern      = '0;
    seg_pattern[6:0] = hex7(4'(rd_data));
    seg_pattern[7]   = (rd_addr_q == LAST_ADDR);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      dwell_q      <= '0;
      acc_q        <= '0;
      disp_q       <= '0;
      seg_q        <= '0;
      led_q        <= '0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      dwell_q      <= dwell_d;
      acc_q        <= acc_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      led_q        <= led_d;
      frame_done_q <= frame_done_d;
      frame_sum_q  <= frame_sum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    dwell_d      = dwell_q;
    acc_d        = acc_q;
    disp_d       = disp_q;
    seg_d        = seg_q;
    led_d        = led_q;
    frame_done_d = 1'b0;
    frame_sum_d  = frame_sum_q;

    case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        dwell_d   = '0;
        acc_d     = '0;
        disp_d    = '0;
        seg_d     = '0;
        led_d     = {5'b0, hold, 2'b0};
        if (scan_en) begin
          state_d = SHOW;
        end
      end

      SHOW: begin
        if (!scan_en) begin
          // Abandon the pass: partial sum and position are discarded,
          // frame_sum keeps the last completed value.
          state_d   = IDLE;
          rd_addr_d = '0;
          dwell_d   = '0;
          acc_d     = '0;
          disp_d    = '0;
          seg_d     = '0;
          led_d     = {5'b0, hold, 2'b0};
        end else begin
          if (!hold) begin
            if (sample) begin
              disp_d = rd_data;
              seg_d  = seg_pattern;
            end
            if (dwell_q == DWELL_LAST) begin
              acc_d   = acc_q + SUM_WIDTH'(show_val);
              dwell_d = '0;
              state_d = BLANK;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
          led_d = {4'(disp_d), 1'b1, hold, 2'(rd_addr_q)};
        end
      end

      BLANK: begin
        if (!scan_en) begin
          state_d   = IDLE;
          rd_addr_d = '0;
          dwell_d   = '0;
          acc_d     = '0;
          disp_d    = '0;
          seg_d     = '0;
          led_d     = {5'b0, hold, 2'b0};
        end else begin
          seg_d     = '0;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          dwell_d   = '0;
          state_d   = SHOW;
          led_d     = {4'(disp_q), 1'b0, hold, 2'(rd_addr_q)};
          if (rd_addr_q == LAST_ADDR) begin
            // acc already holds the last entry, added when its SHOW ended.
            frame_sum_d  = acc_q;
            acc_d        = '0;
            frame_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        rd_addr_d = '0;
        dwell_d   = '0;
        acc_d     = '0;
        seg_d     = '0;
        led_d     = '0;
      end
    endcase
  end

  assign rd_addr    = rd_addr_q;
  assign seg        = seg_q;
  assign led        = led_q;
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;

endmodule

// File: tb/tb_mem_scan_display.sv
// Directed bench for mem_scan_display with DWELL=4 and a 4x4 memory model.
// Cycle c0 of a frame is the first cycle after SHOW of address 0 is entered;
// entry a then shows its pattern on c(5a+1)..c(5a+4) and is blank on c(5a+5).

module tb_mem_scan_display;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       scan_en;
  logic       hold;
  logic [3:0] rd_data;
  logic [1:0] rd_addr;
  logic [7:0] seg;
  logic [7:0] led;
  logic       frame_done;
  logic [5:0] frame_sum;

  logic [3:0] mem [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_2 = ~clk_2;

  assign rd_data = mem[rd_addr];

  mem_scan_display #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(4),
    .DWELL     (4),
    .NBITS_SEG (8)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .scan_en   (scan_en),
    .hold      (hold),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .seg       (seg),
    .led       (led),
    .frame_done(frame_done),
    .frame_sum (frame_sum)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic load_mem(input logic [15:0] v);
    for (int a = 0; a < 4; a++) mem[a] = v[4*a +: 4];
  endtask

  // Walks one full frame starting at c0. segs/vals hold the expected pattern
  // and displayed value per address (byte/nibble a). Optional hold window of
  // hn cycles starting at c(h0), and an optional write of mem[2] at c(wr_k).
  task automatic check_frame(input logic [31:0] segs, input logic [15:0] vals,
                             input logic first_fd, input logic [5:0] prev_sum,
                             input logic [5:0] new_sum, input int h0, input int hn,
                             input int wr_k, input logic [3:0] wr_v);
    int         e;
    int         a;
    int         p;
    logic       hp;
    logic [7:0] es;
    for (int k = 0; k < 20 + hn; k++) begin
      if (hn == 0 || k <= h0) e = k;
      else if (k <= h0 + hn)  e = h0;
      else                    e = k - hn;
      a  = e / 5;
      p  = e % 5;
      es = (p == 0) ? 8'h00 : segs[8*a +: 8];
      check_val("rd_addr", 32'(rd_addr), 32'(a));
      check_val("seg", 32'(seg), 32'(es));
      check_val("frame_done", 32'(frame_done), (k == 0) ? 32'(first_fd) : 32'd0);
      check_val("frame_sum", 32'(frame_sum), 32'(prev_sum));
      if (p == 2) begin
        hp = (hn > 0) && (k - 1 >= h0) && (k - 1 < h0 + hn);
        check_val("led", 32'(led), 32'({vals[4*a +: 4], 1'b1, hp, 2'(a)}));
      end
      if (hn > 0 && k == h0 + 2) check_val("led_hold", 32'(led[2]), 32'd1);
      hold = (hn > 0) && (k >= h0) && (k < h0 + hn);
      if (k == wr_k) mem[2] = wr_v;
      tick(1);
    end
    check_val("end rd_addr", 32'(rd_addr), 32'd0);
    check_val("end seg", 32'(seg), 32'd0);
    check_val("end frame_done", 32'(frame_done), 32'd1);
    check_val("end frame_sum", 32'(frame_sum), 32'(new_sum));
  endtask

  initial begin
    reset   = 1'b1;
    scan_en = 1'b0;
    hold    = 1'b0;
    load_mem(16'hF5A3);
    tick(3);
    check_val("rst seg", 32'(seg), 32'd0);
    check_val("rst led", 32'(led), 32'd0);
    check_val("rst rd_addr", 32'(rd_addr), 32'd0);
    check_val("rst frame_done", 32'(frame_done), 32'd0);
    check_val("rst frame_sum", 32'(frame_sum), 32'd0);

    reset = 1'b0;
    tick(2);
    check_val("idle seg", 32'(seg), 32'd0);
    check_val("idle led", 32'(led), 32'd0);
    scan_en = 1'b1;
    tick(1);

    // Memory {3,A,5,F}: 3+10+5+15 = 33
    check_frame(32'hF16D774F, 16'hF5A3, 1'b0, 6'h00, 6'h21, 0, 0, -1, 4'h0);
    // All F: 60, fills the 6-bit sum without overflow
    load_mem(16'hFFFF);
    check_frame(32'hF1717171, 16'hFFFF, 1'b1, 6'h21, 6'h3C, 0, 0, -1, 4'h0);
    // Hold for 7 cycles while address 1 is on display
    load_mem(16'hF5A3);
    check_frame(32'hF16D774F, 16'hF5A3, 1'b1, 6'h3C, 6'h21, 6, 7, -1, 4'h0);
    // Rewrite mem[2] mid-dwell: this visit still shows and sums 5
    check_frame(32'hF16D774F, 16'hF5A3, 1'b1, 6'h21, 6'h21, 0, 0, 12, 4'h9);
    // Next frame picks up the 9: 3+10+9+15 = 37
    check_frame(32'hF16F774F, 16'hF9A3, 1'b1, 6'h21, 6'h25, 0, 0, -1, 4'h0);

    // Drop scan_en while address 2 is shown
    tick(12);
    check_val("abort pre seg", 32'(seg), 32'h6F);
    check_val("abort pre rd_addr", 32'(rd_addr), 32'd2);
    scan_en = 1'b0;
    tick(1);
    check_val("abort seg", 32'(seg), 32'd0);
    check_val("abort rd_addr", 32'(rd_addr), 32'd0);
    check_val("abort led", 32'(led), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("abort frame_done", 32'(frame_done), 32'd0);
      check_val("abort frame_sum", 32'(frame_sum), 32'h25);
      tick(1);
    end
    mem[2]  = 4'h5;
    scan_en = 1'b1;
    tick(1);
    // Restart from address 0 with a cleared partial sum
    check_frame(32'hF16D774F, 16'hF5A3, 1'b0, 6'h25, 6'h21, 0, 0, -1, 4'h0);

    // Reset during the last BLANK, where frame_done would be produced
    tick(19);
    check_val("pre-rst rd_addr", 32'(rd_addr), 32'd3);
    check_val("pre-rst seg", 32'(seg), 32'hF1);
    reset = 1'b1;
    tick(1);
    check_val("blank-rst frame_done", 32'(frame_done), 32'd0);
    check_val("blank-rst frame_sum", 32'(frame_sum), 32'd0);
    check_val("blank-rst seg", 32'(seg), 32'd0);
    check_val("blank-rst led", 32'(led), 32'd0);
    check_val("blank-rst rd_addr", 32'(rd_addr), 32'd0);
    tick(1);
    check_val("rst-held seg", 32'(seg), 32'd0);
    check_val("rst-held led", 32'(led), 32'd0);
    reset = 1'b0;
    tick(1);
    check_frame(32'hF16D774F, 16'hF5A3, 1'b0, 6'h00, 6'h21, 0, 0, -1, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
